// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: widths, reset PC, canonical NOP and the fetch FSM states.
package riscv_pkg;

  localparam int unsigned XLEN      = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [63:0] RESET_PC  = 64'h0;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous first-word-fall-through FIFO with a flush that overrides push and pop.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module prefetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_c;
  logic             do_push_c;
  logic             do_pop_c;

  assign full_c    = (count_q == CW'(DEPTH));
  assign valid_o   = (count_q != '0);
  assign data_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign do_pop_c  = pop_i & valid_o;
  assign do_push_c = push_i & (~full_c | do_pop_c);

  // Pointer and count update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push_c) - CW'(do_pop_c);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// Instruction fetch front end: credit-limited in-order word fetch, (pc, instr) queue toward IF/ID,
// and redirect handling that discards responses to fetches still in flight at the redirect.
module ifetch_prefetch_queue #(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [XLEN-1:0]        imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [31:0]            imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [31:0]            out_instr,
  output logic [$clog2(DEPTH):0] occupancy
);

  import riscv_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = XLEN + 32;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic            req_valid_c, req_fire_c, rsp_fire_c;
  logic            push_c, pop_c, credit_ok_c;
  logic [CW-1:0]   occ_c, shadow_cnt_c, outstanding_c;
  logic            q_valid_c, shadow_valid_c;
  logic [EW-1:0]   q_head_c;
  logic [XLEN-1:0] shadow_pc_c;

  // The shadow only ever holds live requests and is emptied on redirect, while
  // drop_cnt only counts stale ones, so together they give the in-flight total.
  assign outstanding_c = drop_cnt_q + shadow_cnt_c;
  assign credit_ok_c   = (SW'(occ_c) + SW'(outstanding_c)) < SW'(DEPTH);

  assign rsp_fire_c  = imem_rsp_valid;
  assign req_valid_c = ~reset & (state_q == FETCH) & ~redirect_valid & credit_ok_c;
  assign req_fire_c  = req_valid_c & imem_req_ready;
  assign push_c      = rsp_fire_c & ~redirect_valid & (state_q == FETCH) & shadow_valid_c;
  assign pop_c       = q_valid_c & out_ready & ~redirect_valid;

  // Next-state: redirect overrides everything; DRAIN swallows stale responses.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      drop_cnt_d = outstanding_c - CW'(rsp_fire_c);
      state_d    = (drop_cnt_d != '0) ? DRAIN : FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (req_fire_c) fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        DRAIN: begin
          if (rsp_fire_c) drop_cnt_d = drop_cnt_q - CW'(1);
          if (drop_cnt_d == '0) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  prefetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_entry_q (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect_valid),
    .push_i      (push_c),
    .push_data_i ({shadow_pc_c, imem_rsp_data}),
    .pop_i       (pop_c),
    .valid_o     (q_valid_c),
    .data_o      (q_head_c),
    .count_o     (occ_c)
  );

  // Addresses of issued requests, consumed in order as their responses are queued.
  prefetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_shadow (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect_valid),
    .push_i      (req_fire_c),
    .push_data_i (fetch_pc_q),
    .pop_i       (push_c),
    .valid_o     (shadow_valid_c),
    .data_o      (shadow_pc_c),
    .count_o     (shadow_cnt_c)
  );

  assign imem_req_valid = req_valid_c;
  assign imem_req_addr  = fetch_pc_q;
  assign out_valid      = q_valid_c;
  assign out_pc         = q_valid_c ? q_head_c[EW-1:32] : '0;
  assign out_instr      = q_valid_c ? q_head_c[31:0] : NOP_INSTR;
  assign occupancy      = occ_c;

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Randomised bench: memory model tags requests with a redirect epoch; a monitor checks the
// delivered (pc, instr) stream, occupancy and the credit rule against a queue-based model.
module tb_ifetch_prefetch_queue;
  import riscv_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] due;
    logic [31:0] ep;
  } req_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  occupancy;

  req_t        pending[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_pc;
  logic [63:0] prev_fire_addr;
  int unsigned epoch = 0;
  int unsigned cyc = 0;
  bit          run_mon = 1'b0;
  bit          wrap_seen = 1'b0;
  int          first_valid_cyc = -1;
  int unsigned lat_min, lat_max, p_rdy, p_ordy, p_redir;
  bit          force_redir = 1'b0;
  logic [63:0] force_pc;

  always #5 clk = ~clk;

  ifetch_prefetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .occupancy      (occupancy)
  );

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return 32'h0010_0093 + pc[33:2];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever IF/ID accepts the head.
  always @(negedge clk) begin : monitor
    int   stale;
    int   occ_m;
    exp_t e;
    if (run_mon) begin
      stale = 0;
      foreach (pending[i]) if (pending[i].ep != epoch) stale++;
      occ_m = exp_q.size();
      chk("occupancy", 64'(occupancy), 64'(occ_m));
      chk("out_valid", 64'(out_valid), 64'(occ_m > 0));
      chk("req_valid", 64'(imem_req_valid),
          64'(!redirect_valid && stale == 0 && (occ_m + pending.size()) < DEPTH));
      if (occ_m == 0) chk("empty_nop", 64'(out_instr), 64'(NOP_INSTR));
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = int'(cyc);
      if (out_valid && out_ready && !redirect_valid) begin
        if (occ_m == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got pc %h expected no entry (cycle %0d)", out_pc, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_instr", 64'(out_instr), 64'(e.instr));
        end
      end
    end
  end

  task automatic drive_inputs();
    req_t h;
    imem_req_ready = ($urandom_range(99) < p_rdy);
    out_ready      = ($urandom_range(99) < p_ordy);
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
      force_redir    = 1'b0;
    end else if ($urandom_range(99) < p_redir) begin
      redirect_valid = 1'b1;
      if ($urandom_range(3) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(31));
      else                        redirect_pc = 64'($urandom_range(32'hFFFF));
    end else begin
      redirect_valid = 1'b0;
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pending.size() > 0) begin
      h = pending[0];
      if (h.due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(h.pc);
      end
    end
  endtask

  // One clock: model the edge, then drive the next cycle's inputs.
  task automatic cycle_step();
    req_t r;
    int unsigned lat;
    @(negedge clk);
    #1;
    if (imem_rsp_valid) begin
      r = pending.pop_front();
      if (!redirect_valid && r.ep == epoch) exp_q.push_back('{pc: r.pc, instr: instr_of(r.pc)});
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, model_pc);
      if (imem_req_addr == 64'h0 && prev_fire_addr == 64'hFFFF_FFFF_FFFF_FFFC) wrap_seen = 1'b1;
      prev_fire_addr = imem_req_addr;
      lat = $urandom_range(lat_max, lat_min);
      pending.push_back('{pc: model_pc, due: cyc + 1 + lat, ep: epoch});
      model_pc = model_pc + 64'd4;
    end
    if (redirect_valid) begin
      exp_q.delete();
      epoch++;
      model_pc = redirect_pc & ~64'h3;
    end
    @(posedge clk);
    cyc++;
    #1;
    drive_inputs();
  endtask

  task automatic set_knobs(input int unsigned lmin, input int unsigned lmax, input int unsigned rdy,
                           input int unsigned ordy, input int unsigned redir);
    lat_min = lmin; lat_max = lmax; p_rdy = rdy; p_ordy = ordy; p_redir = redir;
  endtask

  // Asynchronous reset: outputs must take reset values without a clock edge.
  task automatic do_reset();
    run_mon = 1'b0;
    reset   = 1'b1;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'(NOP_INSTR));
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    pending.delete();
    exp_q.delete();
    epoch++;
    model_pc = RESET_PC;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    first_valid_cyc = -1;
    run_mon = 1'b1;
    drive_inputs();
  endtask

  initial begin
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    prev_fire_addr = '1;
    set_knobs(0, 0, 100, 100, 0);
    do_reset();

    // Single-cycle memory stream, then backpressure and release.
    repeat (20) cycle_step();
    chk("first_valid_cycle", 64'(first_valid_cyc), 64'd2);
    p_ordy = 0;
    repeat (10) cycle_step();
    chk("bp_occupancy", 64'(occupancy), 64'd4);
    chk("bp_req_valid", 64'(imem_req_valid), 64'd0);
    p_ordy = 100;
    repeat (10) cycle_step();

    // Redirect with three fetches in flight.
    set_knobs(2, 2, 100, 100, 0);
    repeat (8) cycle_step();
    force_pc = 64'h100; force_redir = 1'b1;
    repeat (14) cycle_step();

    // Misaligned target and address wrap.
    set_knobs(0, 0, 100, 100, 0);
    force_pc = 64'h203; force_redir = 1'b1;
    cycle_step();
    cycle_step();
    chk("misaligned_addr", imem_req_addr, 64'h200);
    repeat (6) cycle_step();
    force_pc = 64'hFFFF_FFFF_FFFF_FFFC; force_redir = 1'b1;
    repeat (10) cycle_step();
    chk("wrap_to_zero", 64'(wrap_seen), 64'd1);

    // Randomised traffic with occasional redirects.
    set_knobs(0, 4, 70, 70, 5);
    repeat (3000) cycle_step();

    // Reset in the middle of a drain with two stale fetches.
    set_knobs(3, 3, 100, 100, 0);
    do_reset();
    cycle_step();
    force_pc = 64'h400; force_redir = 1'b1;
    cycle_step();
    cycle_step();
    chk("drain_stale_cnt", 64'(pending.size()), 64'd2);
    chk("drain_no_req", 64'(imem_req_valid), 64'd0);
    #2;
    do_reset();
    chk("restart_addr", imem_req_addr, RESET_PC);
    set_knobs(0, 2, 90, 90, 0);
    repeat (30) cycle_step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
